// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with double-buffered glyph codes
// and per-digit blinking. Code/mask updates take effect only at frame boundaries.
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] codes,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [4*NUM_DIGITS-1:0] BLANK_CODES = {NUM_DIGITS{4'hF}};

  logic [CW-1:0]           cnt_reg, cnt_next;
  logic [IW-1:0]           idx_reg, idx_next;
  logic [FW-1:0]           frame_reg, frame_next;
  logic                    phase_reg, phase_next;
  logic [4*NUM_DIGITS-1:0] active_codes_reg, active_codes_next;
  logic [NUM_DIGITS-1:0]   active_mask_reg, active_mask_next;
  logic [4*NUM_DIGITS-1:0] shadow_codes_reg, shadow_codes_next;
  logic [NUM_DIGITS-1:0]   shadow_mask_reg, shadow_mask_next;
  logic                    pending_reg, pending_next;
  logic [6:0]              seg_reg, seg_next;
  logic [NUM_DIGITS-1:0]   an_reg, an_next;

  logic       tick, frame_end, blanked;
  logic [3:0] sel_code;
  logic [3:0] digit_code [NUM_DIGITS];

  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'd0:    glyph = 7'b1111110;
      4'd1:    glyph = 7'b0110000;
      4'd2:    glyph = 7'b1101101;
      4'd3:    glyph = 7'b1111001;
      4'd4:    glyph = 7'b0110011;
      4'd5:    glyph = 7'b1011011;
      4'd6:    glyph = 7'b1011111;
      4'd7:    glyph = 7'b1110000;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1111011;
      4'd10:   glyph = 7'b1100011;
      4'd11:   glyph = 7'b0011101;
      4'd12:   glyph = 7'b0000001;
      default: glyph = 7'b0000000;
    endcase
  endfunction

  assign tick      = en && (cnt_reg == CNT_LAST);
  assign frame_end = tick && (idx_reg == IDX_LAST);

  always_comb begin
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    frame_next = frame_reg;
    phase_next = phase_reg;
    if (!en) begin
      cnt_next   = '0;
      idx_next   = '0;
      frame_next = '0;
      phase_next = 1'b0;
    end else begin
      cnt_next = tick ? '0 : cnt_reg + 1'b1;
      if (tick)
        idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      if (frame_end) begin
        if (frame_reg == FRM_LAST) begin
          frame_next = '0;
          phase_next = ~phase_reg;
        end else begin
          frame_next = frame_reg + 1'b1;
        end
      end
    end
  end

  // While disabled there is no frame to wait for, so updates apply at once.
  always_comb begin
    shadow_codes_next = shadow_codes_reg;
    shadow_mask_next  = shadow_mask_reg;
    active_codes_next = active_codes_reg;
    active_mask_next  = active_mask_reg;
    pending_next      = pending_reg;
    if (load) begin
      shadow_codes_next = codes;
      shadow_mask_next  = blink_mask;
    end
    if (!en || frame_end) begin
      if (load) begin
        active_codes_next = codes;
        active_mask_next  = blink_mask;
      end else if (pending_reg) begin
        active_codes_next = shadow_codes_reg;
        active_mask_next  = shadow_mask_reg;
      end
      pending_next = 1'b0;
    end else if (load) begin
      pending_next = 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_code[gi] = active_codes_reg[4*gi +: 4];
    assign an_next[gi]    = !(en && (idx_reg == IW'(gi)));
  end

  assign sel_code = digit_code[idx_reg];
  assign blanked  = phase_reg && active_mask_reg[idx_reg];
  assign seg_next = (!en || blanked) ? 7'h7F : ~glyph(sel_code);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg          <= '0;
      idx_reg          <= '0;
      frame_reg        <= '0;
      phase_reg        <= 1'b0;
      active_codes_reg <= BLANK_CODES;
      active_mask_reg  <= '0;
      shadow_codes_reg <= BLANK_CODES;
      shadow_mask_reg  <= '0;
      pending_reg      <= 1'b0;
      seg_reg          <= 7'h7F;
      an_reg           <= '1;
    end else begin
      cnt_reg          <= cnt_next;
      idx_reg          <= idx_next;
      frame_reg        <= frame_next;
      phase_reg        <= phase_next;
      active_codes_reg <= active_codes_next;
      active_mask_reg  <= active_mask_next;
      shadow_codes_reg <= shadow_codes_next;
      shadow_mask_reg  <= shadow_mask_next;
      pending_reg      <= pending_next;
      seg_reg          <= seg_next;
      an_reg           <= an_next;
    end
  end

  assign seg     = seg_reg;
  assign an      = an_reg;
  assign pending = pending_reg;

endmodule
